// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock divider controller.
//   state_e       : controller FSM states (idle / running / draining last period)
//   DIV_MIN       : smallest legal divide ratio
//   DIV_W_DEFAULT : default width of the divide-ratio field
package clk_div_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

    localparam int unsigned DIV_MIN       = 2;
    localparam int unsigned DIV_W_DEFAULT = 8;

endpackage

// File: rtl/clk_div_core.sv
// Period counter plus registered divided clock and tick generation.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   div        : current divide ratio (>= 2)
//   run        : keep counting through this edge; low parks counter at 0, clk_o low
//   restart    : start a fresh period at this edge (cnt<=0, clk_o<=1, tick<=1)
//   clk_o      : divided clock, high for div-(div>>1) cycles of each period
//   tick       : one-cycle pulse in the cycle clk_o rises
//   boundary   : current cycle is the last count of the period (cnt == div-1)
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div,
    input  logic             run,
    input  logic             restart,
    output logic             clk_o,
    output logic             tick,
    output logic             boundary
);

    localparam logic [DIV_W-1:0] CntOne = DIV_W'(1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] hi_len;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;

    // Odd ratios put the extra cycle in the high phase.
    assign hi_len   = div - (div >> 1);
    assign boundary = (cnt_q == (div - CntOne));

    always_comb begin
        cnt_d  = '0;
        clk_d  = 1'b0;
        tick_d = 1'b0;
        if (restart || (run && boundary)) begin
            cnt_d  = '0;
            clk_d  = 1'b1;
            tick_d = 1'b1;
        end else if (run) begin
            cnt_d = cnt_q + CntOne;
            clk_d = (cnt_d < hi_len);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign clk_o = clk_q;
    assign tick  = tick_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock divider controller: run/drain FSM, ratio handshake and pending ratio.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   en         : level request to run the divided clock
//   cfg_valid  : new ratio offered on cfg_div
//   cfg_div    : requested ratio N
//   cfg_ready  : a new ratio can be accepted (low while a ratio is pending)
//   cfg_err    : one-cycle pulse after an offered ratio below DIV_MIN was discarded
//   clk_o      : divided clock (registered)
//   tick       : one-cycle pulse in the cycle clk_o rises
//   busy       : FSM is not idle
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W       = DIV_W_DEFAULT,
    parameter int unsigned DIV_DEFAULT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_o,
    output logic             tick,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_cur_q, div_cur_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic             cfg_err_q, cfg_err_d;
    logic             boundary;
    logic             run;
    logic             restart;
    logic             xfer;
    logic             div_ok;
    logic             apply;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (en) state_d = StRun;
            StRun:   if (!en) state_d = boundary ? StIdle : StDrain;
            StDrain: begin
                // Re-enabling while draining keeps the current phase untouched.
                if (en)            state_d = StRun;
                else if (boundary) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Core looks at the next state so the final boundary edge already drives clk_o low.
    assign run     = (state_d != StIdle);
    assign restart = (state_q == StIdle) && (state_d == StRun);

    assign cfg_ready = !pend_valid_q;
    assign xfer      = cfg_valid && cfg_ready;
    assign div_ok    = (cfg_div >= DIV_W'(DIV_MIN));
    // In idle there is no period to protect, so a leftover pending ratio lands at once.
    assign apply     = pend_valid_q && ((state_q == StIdle) || boundary);

    always_comb begin
        div_cur_d    = div_cur_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        cfg_err_d    = xfer && !div_ok;
        if (apply) begin
            div_cur_d    = pend_q;
            pend_valid_d = 1'b0;
        end
        // xfer needs cfg_ready, so it never coincides with apply.
        if (xfer && div_ok) begin
            if (state_q == StIdle) begin
                div_cur_d = cfg_div;
            end else begin
                pend_d       = cfg_div;
                pend_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            div_cur_q    <= DIV_W'(DIV_DEFAULT);
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cur_q    <= div_cur_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;
    assign busy    = (state_q != StIdle);

    clk_div_core #(
        .DIV_W(DIV_W)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .div      (div_cur_q),
        .run      (run),
        .restart  (restart),
        .clk_o    (clk_o),
        .tick     (tick),
        .boundary (boundary)
    );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: reset values, default/odd ratios, pending
// ratio change, illegal ratios, drain and re-enable, asynchronous reset.
module tb_clk_div_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       cfg_err;
    logic       clk_o;
    logic       tick;
    logic       busy;

    int n_total;
    int n_bad;

    clk_div_ctrl #(
        .DIV_W       (8),
        .DIV_DEFAULT (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_o     (clk_o),
        .tick      (tick),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = 8'd0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, ".clk_o"}, 32'(clk_o), 32'd0);
        check_val({tag, ".tick"}, 32'(tick), 32'd0);
        check_val({tag, ".busy"}, 32'(busy), 32'd0);
        check_val({tag, ".ready"}, 32'(cfg_ready), 32'd1);
        check_val({tag, ".err"}, 32'(cfg_err), 32'd0);
    endtask

    // Entered with cnt==0 just established; pat MSB-first gives clk_o per cycle.
    task automatic check_period(input string tag, input int n, input logic [15:0] pat);
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("%s.clk[%0d]", tag, i), 32'(clk_o), 32'(pat[n-1-i]));
            check_val($sformatf("%s.tick[%0d]", tag, i), 32'(tick), (i == 0) ? 32'd1 : 32'd0);
            check_val($sformatf("%s.busy[%0d]", tag, i), 32'(busy), 32'd1);
            step();
        end
    endtask

    task automatic load_idle(input logic [7:0] n);
        cfg_valid = 1'b1;
        cfg_div   = n;
        step();
        cfg_valid = 1'b0;
        check_val("load.ready", 32'(cfg_ready), 32'd1);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;

        // Reset state and default ratio 2
        do_reset();
        check_idle("rst");
        step();
        en = 1'b1;  // sampled at the next edge
        step();
        check_period("n2a", 2, 16'b10);
        check_period("n2b", 2, 16'b10);
        check_period("n2c", 2, 16'b10);

        // Odd ratio 5: 3 high / 2 low
        do_reset();
        load_idle(8'd5);
        en = 1'b1;
        step();
        check_period("n5a", 5, 16'b11100);
        check_period("n5b", 5, 16'b11100);

        // Ratio change 4 -> 6 accepted mid-period
        do_reset();
        load_idle(8'd4);
        en = 1'b1;
        step();                    // cnt=0
        check_val("chg.c0", 32'(clk_o), 32'd1);
        check_val("chg.t0", 32'(tick), 32'd1);
        step();                    // cnt=1
        check_val("chg.c1", 32'(clk_o), 32'd1);
        check_val("chg.r1", 32'(cfg_ready), 32'd1);
        cfg_valid = 1'b1;
        cfg_div   = 8'd6;
        step();                    // cnt=2, ratio now pending
        cfg_valid = 1'b0;
        check_val("chg.c2", 32'(clk_o), 32'd0);
        check_val("chg.r2", 32'(cfg_ready), 32'd0);
        step();                    // cnt=3, boundary
        check_val("chg.c3", 32'(clk_o), 32'd0);
        check_val("chg.r3", 32'(cfg_ready), 32'd0);
        step();                    // new period with 6
        check_val("chg.r4", 32'(cfg_ready), 32'd1);
        check_period("n6a", 6, 16'b111000);
        check_period("n6b", 6, 16'b111000);

        // Illegal ratios 1 and 0 while running at 2
        do_reset();
        en = 1'b1;
        step();                    // cnt=0
        cfg_valid = 1'b1;
        cfg_div   = 8'd1;
        step();                    // cnt=1
        cfg_valid = 1'b0;
        check_val("bad1.err", 32'(cfg_err), 32'd1);
        check_val("bad1.ready", 32'(cfg_ready), 32'd1);
        check_val("bad1.clk", 32'(clk_o), 32'd0);
        step();                    // cnt=0
        check_val("bad1.err_off", 32'(cfg_err), 32'd0);
        check_val("bad1.clk2", 32'(clk_o), 32'd1);
        cfg_valid = 1'b1;
        cfg_div   = 8'd0;
        step();                    // cnt=1
        cfg_valid = 1'b0;
        check_val("bad0.err", 32'(cfg_err), 32'd1);
        check_val("bad0.ready", 32'(cfg_ready), 32'd1);
        check_val("bad0.clk", 32'(clk_o), 32'd0);
        step();                    // cnt=0
        check_val("bad0.err_off", 32'(cfg_err), 32'd0);
        check_period("bad.n2a", 2, 16'b10);
        check_period("bad.n2b", 2, 16'b10);

        // Drain at ratio 6, then re-enable during drain
        do_reset();
        load_idle(8'd6);
        en = 1'b1;
        step();                    // cnt=0
        step();                    // cnt=1
        en = 1'b0;
        step();                    // cnt=2, draining
        check_val("dr.c2", 32'(clk_o), 32'd1);
        check_val("dr.b2", 32'(busy), 32'd1);
        step();                    // cnt=3
        check_val("dr.c3", 32'(clk_o), 32'd0);
        step();                    // cnt=4
        check_val("dr.c4", 32'(clk_o), 32'd0);
        step();                    // cnt=5
        check_val("dr.c5", 32'(clk_o), 32'd0);
        check_val("dr.b5", 32'(busy), 32'd1);
        step();                    // idle
        check_idle("dr.idle");
        en = 1'b1;
        step();                    // cnt=0
        step();                    // cnt=1
        en = 1'b0;
        step();                    // cnt=2, draining
        en = 1'b1;
        step();                    // cnt=3, running again
        check_val("re.c3", 32'(clk_o), 32'd0);
        check_val("re.b3", 32'(busy), 32'd1);
        step();                    // cnt=4
        step();                    // cnt=5
        check_val("re.c5", 32'(clk_o), 32'd0);
        step();                    // next period, no gap
        check_period("re.n6", 6, 16'b111000);

        // Async reset mid-period at ratio 8
        do_reset();
        load_idle(8'd8);
        en = 1'b1;
        step();                    // cnt=0
        step();                    // cnt=1
        step();                    // cnt=2
        check_val("ar.pre", 32'(clk_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle("ar.now");
        en = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        check_val("ar.wait", 32'(busy), 32'd0);
        en = 1'b1;
        step();
        check_period("ar.n2a", 2, 16'b10);
        check_period("ar.n2b", 2, 16'b10);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
